// File: rtl/fp_divsqrt_requester.sv
// rtl/fp_divsqrt_requester.sv - issue-side initiator for the shared FP32 div/sqrt unit
module fp_divsqrt_requester #(
  parameter int AL_PTR_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_issueValid,
  output logic                    o_issueReady,
  input  logic                    i_issueIsDivide,
  input  logic [31:0]             i_issueOpA,
  input  logic [31:0]             i_issueOpB,
  input  logic [AL_PTR_WIDTH-1:0] i_issueAlPtr,
  input  logic                    i_unitFree,
  input  logic                    i_unitFinished,
  input  logic [31:0]             i_unitResult,
  output logic                    o_unitAcquire,
  output logic [AL_PTR_WIDTH-1:0] o_unitAcquirePtr,
  output logic                    o_unitReq,
  output logic                    o_unitIsDivide,
  output logic [31:0]             o_unitDataA,
  output logic [31:0]             o_unitDataB,
  output logic                    o_unitRelease,
  output logic                    o_wbValid,
  input  logic                    i_wbReady,
  output logic [AL_PTR_WIDTH-1:0] o_wbAlPtr,
  output logic [31:0]             o_wbData,
  input  logic                    i_flushValid,
  input  logic                    i_flushAll,
  input  logic [AL_PTR_WIDTH-1:0] i_flushHead,
  input  logic [AL_PTR_WIDTH-1:0] i_flushTail,
  output logic                    o_timeoutErr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t                  r_state;
  logic                    r_isDivide;
  logic [31:0]             r_dataA;
  logic [31:0]             r_dataB;
  logic [31:0]             r_result;
  logic [AL_PTR_WIDTH-1:0] r_ptr;
  logic [CNT_W-1:0]        r_waitCnt;
  logic                    r_timeoutErr;

  logic w_flushIssue;
  logic w_flushLatched;
  logic w_accept;
  logic w_wbValid;
  logic w_release;

  // Range test on the circular active list; head==tail is an empty range unless flushAll
  function automatic logic flush_hit(
    input logic                    vld,
    input logic                    all,
    input logic [AL_PTR_WIDTH-1:0] head,
    input logic [AL_PTR_WIDTH-1:0] tail,
    input logic [AL_PTR_WIDTH-1:0] p
  );
    if (!vld) return 1'b0;
    if (all) return 1'b1;
    if (head <= tail) return (p >= head) && (p < tail);
    return (p >= head) || (p < tail);
  endfunction

  assign w_flushIssue   = flush_hit(i_flushValid, i_flushAll, i_flushHead, i_flushTail, i_issueAlPtr);
  assign w_flushLatched = flush_hit(i_flushValid, i_flushAll, i_flushHead, i_flushTail, r_ptr);

  // Handshake strobes are gated by reset so every output reads 0 while rst is held
  assign o_issueReady = !i_rst && (r_state == S_IDLE) && i_unitFree;
  assign w_accept     = o_issueReady && i_issueValid && !w_flushIssue;
  assign w_wbValid    = !i_rst && (r_state == S_WB) && !w_flushLatched;
  assign w_release    = w_wbValid && i_wbReady;

  assign o_unitAcquire    = w_accept;
  assign o_unitAcquirePtr = w_accept ? i_issueAlPtr : '0;
  assign o_unitReq        = !i_rst && (r_state == S_REQ) && !w_flushLatched;
  assign o_unitRelease    = w_release;
  assign o_wbValid        = w_wbValid;
  assign o_unitIsDivide   = r_isDivide;
  assign o_unitDataA      = r_dataA;
  assign o_unitDataB      = r_dataB;
  assign o_wbAlPtr        = r_ptr;
  assign o_wbData         = r_result;
  assign o_timeoutErr     = r_timeoutErr;

  // Request FSM: acquire, single-cycle req, wait for result, hold for writeback; flush aborts any busy state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_isDivide   <= 1'b0;
      r_dataA      <= '0;
      r_dataB      <= '0;
      r_result     <= '0;
      r_ptr        <= '0;
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_isDivide <= i_issueIsDivide;
            r_dataA    <= i_issueOpA;
            r_dataB    <= i_issueOpB;
            r_ptr      <= i_issueAlPtr;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_flushLatched) begin
            r_state <= S_IDLE;
          end else begin
            r_waitCnt <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_flushLatched) begin
            r_state <= S_IDLE;
          end else begin
            if (r_waitCnt != CNT_MAX) r_waitCnt <= r_waitCnt + 1'b1;
            if (r_waitCnt == CNT_LAST) r_timeoutErr <= 1'b1;
            if (i_unitFinished) begin
              r_result <= i_unitResult;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (w_flushLatched || w_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_divsqrt_requester.md
Name: fp_divsqrt_requester

Overview:
Issue-side initiator for the shared FP32 div/sqrt unit. Accepts one div/sqrt op from the issue stage, drives the unit's Acquire -> Req -> (Finished) -> Release handshake, captures the result and presents it to writeback. Cancels itself on selective pipeline flush. Sits between the FP issue/register-read stage and the div/sqrt unit; one instance per unit lane.

Parameters:
AL_PTR_WIDTH, 6, active-list index width
TIMEOUT_CYCLES, 64, cycles in WAIT before the watchdog sets timeoutErr

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issueValid  in  1  op offered by issue stage
issueReady  out  1  requester accepts op this cycle
issueIsDivide  in  1  1 = div, 0 = sqrt
issueOpA  in  32  dividend / radicand
issueOpB  in  32  divisor (ignored for sqrt)
issueAlPtr  in  AL_PTR_WIDTH  active-list index of op
unitFree  in  1  unit will be free next cycle
unitFinished  in  1  unit holds a valid result (level)
unitResult  in  32  unit result, valid while unitFinished
unitAcquire  out  1  reserve unit
unitAcquirePtr  out  AL_PTR_WIDTH  active-list index sent with Acquire
unitReq  out  1  start operation (1-cycle pulse)
unitIsDivide  out  1  latched op type
unitDataA  out  32  latched operand A
unitDataB  out  32  latched operand B
unitRelease  out  1  result consumed, free unit (1-cycle pulse)
wbValid  out  1  result available to writeback
wbReady  in  1  writeback accepts
wbAlPtr  out  AL_PTR_WIDTH  active-list index of result
wbData  out  32  captured result
flushValid  in  1  recovery phase active
flushAll  in  1  flush every in-flight op
flushHead  in  AL_PTR_WIDTH  flush range head (inclusive)
flushTail  in  AL_PTR_WIDTH  flush range tail (exclusive)
timeoutErr  out  1  sticky watchdog error

Behaviour:
- States: IDLE, REQ, WAIT, WB. Reset -> IDLE; latched ptr/operands/result = 0; waitCnt = 0; timeoutErr = 0; all outputs 0.
- flushHit(p) = flushValid & (flushAll | (head<=tail ? head<=p && p<tail : p>=head || p<tail)); head==tail with flushAll=0 -> empty range.
- IDLE: issueReady = unitFree. Accept on issueValid & issueReady & !flushHit(issueAlPtr): same cycle unitAcquire=1, unitAcquirePtr=issueAlPtr; latch op type, operands, ptr; -> REQ. If flushHit(issueAlPtr), no Acquire, stay IDLE (op dropped).
- REQ: unitReq=1 for exactly one cycle with latched operands; waitCnt cleared; -> WAIT.
- WAIT: waitCnt +1 per cycle, saturating at TIMEOUT_CYCLES; reaching TIMEOUT_CYCLES sets timeoutErr (sticky until rst); state unchanged. When unitFinished=1: wbData <= unitResult; -> WB.
- WB: wbValid=1, wbAlPtr=latched ptr, wbData stable. On wbValid & wbReady: unitRelease=1 that cycle; -> IDLE. Hold indefinitely while wbReady=0.
- issueReady=0 in every state except IDLE.
- Flush (any non-IDLE state, flushHit(latched ptr)=1): -> IDLE next cycle; suppress unitReq/unitRelease/wbValid that cycle; no Release (unit frees itself on flush). Flush beats simultaneous wb handshake or unitFinished.
- Flush not hitting latched ptr: no effect.
- Latency: accept -> Req = 1 cycle; unitFinished -> wbValid = 1 cycle; handshake -> issueReady possible next cycle (subject to unitFree).
- rst mid-operation: immediate return to reset values; no Release issued.
- unitAcquire, unitReq, unitRelease mutually exclusive in any cycle.

Test Plan:
- Div 0x3F800000 / 0x40000000, ptr 5, wbReady=1, unit finishes 10 cycles after Req -> Acquire(ptr 5) at accept, Req next cycle, wbValid with wbData=0x3F000000, wbAlPtr=5 one cycle after unitFinished, Release same cycle.
- Sqrt 0x40800000, wbReady held 0 for 4 cycles -> wbValid held 4 cycles, data 0x40000000 stable, single Release on cycle wbReady=1.
- Wrap-around flush head=60, tail=2, latched ptr=1 in WAIT -> IDLE next cycle, no wbValid, no Release; repeat with ptr=3 -> unaffected, completes normally.
- Flush coinciding with WB handshake (ptr in range) -> no Release, no writeback, IDLE next cycle; issueValid with ptr in range while IDLE -> no Acquire.
- unitFree=0 in IDLE with issueValid=1 -> issueReady=0, no Acquire; unitFree rises -> accept same cycle.
- Unit never finishes -> timeoutErr=1 exactly TIMEOUT_CYCLES=64 cycles after entering WAIT, stays 1 until rst; rst returns all outputs to 0.
